flash_erase_seq: RTL and testbench

FLASH_ERASE_SEQ -- requirements
Module: flash_erase_seq

---
 rtl/flash_ctrl_pkg.sv | 37 +++
 rtl/flash_erase_timer.sv | 36 +++
 rtl/flash_erase_seq.sv | 184 ++++++++++++++++++
 tb/tb_flash_erase_seq.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/flash_ctrl_pkg.sv
// rtl/flash_ctrl_pkg.sv - shared erase op encodings, error code bits and flash geometry defaults
package flash_ctrl_pkg;

    typedef enum logic [1:0] {
        OP_PAGE    = 2'd0,
        OP_BANK    = 2'd1,
        OP_RANGE   = 2'd2,
        OP_ILLEGAL = 2'd3
    } erase_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } erase_state_e;

    localparam int unsigned ERR_W           = 3;
    localparam int unsigned ERR_FLASH_BIT   = 0;
    localparam int unsigned ERR_TIMEOUT_BIT = 1;
    localparam int unsigned ERR_ILLEGAL_BIT = 2;

    localparam logic [ERR_W-1:0] ERR_NONE    = 3'b000;
    localparam logic [ERR_W-1:0] ERR_FLASH   = 3'b001;
    localparam logic [ERR_W-1:0] ERR_TIMEOUT = 3'b010;
    localparam logic [ERR_W-1:0] ERR_ILLEGAL = 3'b100;

    localparam logic FLASH_OP_PAGE = 1'b0;
    localparam logic FLASH_OP_BANK = 1'b1;

    localparam int unsigned DEF_ADDR_W         = 17;
    localparam int unsigned DEF_WORDS_PER_PAGE = 256;
    localparam int unsigned DEF_PAGES_PER_BANK = 256;
    localparam int unsigned DEF_NUM_BANKS      = 2;
    localparam int unsigned DEF_TIMEOUT_W      = 16;

endpackage

// File: rtl/flash_erase_timer.sv
// rtl/flash_erase_timer.sv - loadable down-counter that pulses expire_o when it steps from 1 to 0
module flash_erase_timer #(
    parameter int unsigned Width = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [Width-1:0] load_val_i,
    input  logic             en_i,
    output logic             expire_o
);

    logic [Width-1:0] count_q;
    logic [Width-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (en_i && (count_q != '0)) begin
            count_d = count_q - Width'(1);
        end
    end

    // Pulses only on the decrement that reaches zero; a parked zero count stays quiet.
    assign expire_o = en_i && !load_i && (count_q == Width'(1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/flash_erase_seq.sv
// rtl/flash_erase_seq.sv - page/bank/range erase sequencer driving a single-request flash phy
module flash_erase_seq
    import flash_ctrl_pkg::*;
#(
    parameter int unsigned AddrW        = DEF_ADDR_W,
    parameter int unsigned WordsPerPage = DEF_WORDS_PER_PAGE,
    parameter int unsigned PagesPerBank = DEF_PAGES_PER_BANK,
    parameter int unsigned NumBanks     = DEF_NUM_BANKS,
    parameter int unsigned TimeoutW     = DEF_TIMEOUT_W,
    localparam int unsigned CountW      = $clog2(PagesPerBank*NumBanks) + 1
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                op_start_i,
    input  logic [1:0]          op_type_i,
    input  logic [AddrW-1:0]    op_addr_i,
    input  logic [CountW-1:0]   op_num_pages_i,
    input  logic [TimeoutW-1:0] op_timeout_i,
    output logic                busy_o,
    output logic                op_done_o,
    output logic                op_err_o,
    output logic [ERR_W-1:0]    op_err_code_o,
    output logic                flash_req_o,
    output logic                flash_op_o,
    output logic [AddrW-1:0]    flash_addr_o,
    input  logic                flash_done_i,
    input  logic                flash_error_i
);

    localparam int unsigned PageBits   = $clog2(WordsPerPage);
    localparam int unsigned BankBits   = $clog2(WordsPerPage*PagesPerBank);
    localparam int unsigned TotalPages = PagesPerBank*NumBanks;

    localparam logic [AddrW-1:0] PageMask = {AddrW{1'b1}} << PageBits;
    localparam logic [AddrW-1:0] BankMask = {AddrW{1'b1}} << BankBits;
    localparam logic [AddrW-1:0] PageStep = AddrW'(WordsPerPage);

    erase_state_e        state_q, state_d;
    erase_op_e           type_q, type_d;
    logic [AddrW-1:0]    addr_q, addr_d;
    logic [CountW-1:0]   remain_q, remain_d;
    logic [TimeoutW-1:0] timeout_q, timeout_d;

    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic [ERR_W-1:0]    err_code_q, err_code_d;
    logic                req_q, req_d;
    logic                fop_q, fop_d;
    logic [AddrW-1:0]    faddr_q, faddr_d;

    logic [31:0]         start_page;
    logic [31:0]         end_page;
    logic                reject;
    logic                timer_load;
    logic                timer_en;
    logic                timer_expire;
    logic [ERR_W-1:0]    err_next;

    // Range end is one past the last page touched; equal to TotalPages is still legal.
    assign start_page = 32'(op_addr_i >> PageBits);
    assign end_page   = start_page + 32'(op_num_pages_i);
    assign reject     = (op_type_i == OP_ILLEGAL) ||
                        ((op_type_i == OP_RANGE) &&
                         ((op_num_pages_i == '0) || (end_page > 32'(TotalPages))));

    assign timer_load = (state_q == ST_ISSUE);
    assign timer_en   = (state_q == ST_WAIT) && (timeout_q != '0);

    flash_erase_timer #(
        .Width (TimeoutW)
    ) u_timer (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .load_i     (timer_load),
        .load_val_i (timeout_q),
        .en_i       (timer_en),
        .expire_o   (timer_expire)
    );

    always_comb begin
        state_d   = state_q;
        type_d    = type_q;
        addr_d    = addr_q;
        remain_d  = remain_q;
        timeout_d = timeout_q;
        err_next  = ERR_NONE;

        unique case (state_q)
            ST_IDLE: begin
                if (op_start_i) begin
                    type_d    = erase_op_e'(op_type_i);
                    addr_d    = (op_type_i == OP_BANK) ? (op_addr_i & BankMask)
                                                       : (op_addr_i & PageMask);
                    remain_d  = op_num_pages_i;
                    timeout_d = op_timeout_i;
                    if (reject) begin
                        state_d  = ST_DONE;
                        err_next = ERR_ILLEGAL;
                    end else begin
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // Error outranks a coincident done; a real completion outranks the timeout.
                if (flash_error_i) begin
                    state_d  = ST_DONE;
                    err_next = ERR_FLASH;
                end else if (flash_done_i) begin
                    if ((type_q == OP_RANGE) && (remain_q > CountW'(1))) begin
                        addr_d   = addr_q + PageStep;
                        remain_d = remain_q - CountW'(1);
                        state_d  = ST_ISSUE;
                    end else begin
                        state_d = ST_DONE;
                    end
                end else if (timer_expire) begin
                    state_d  = ST_DONE;
                    err_next = ERR_TIMEOUT;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_comb begin
        busy_d     = (state_d != ST_IDLE);
        done_d     = (state_d == ST_DONE);
        err_code_d = done_d ? err_next : ERR_NONE;
        err_d      = done_d && (err_next != ERR_NONE);
        req_d      = (state_d == ST_WAIT);
        fop_d      = req_d && (type_q == OP_BANK) ? FLASH_OP_BANK : FLASH_OP_PAGE;
        faddr_d    = req_d ? addr_q : '0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            type_q     <= OP_PAGE;
            addr_q     <= '0;
            remain_q   <= '0;
            timeout_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= ERR_NONE;
            req_q      <= 1'b0;
            fop_q      <= FLASH_OP_PAGE;
            faddr_q    <= '0;
        end else begin
            state_q    <= state_d;
            type_q     <= type_d;
            addr_q     <= addr_d;
            remain_q   <= remain_d;
            timeout_q  <= timeout_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
            req_q      <= req_d;
            fop_q      <= fop_d;
            faddr_q    <= faddr_d;
        end
    end

    assign busy_o        = busy_q;
    assign op_done_o     = done_q;
    assign op_err_o      = err_q;
    assign op_err_code_o = err_code_q;
    assign flash_req_o   = req_q;
    assign flash_op_o    = fop_q;
    assign flash_addr_o  = faddr_q;

endmodule

// File: tb/tb_flash_erase_seq.sv
// tb/tb_flash_erase_seq.sv - directed scoreboard bench for flash_erase_seq
module tb_flash_erase_seq;

    localparam int AW = 17;
    localparam int CW = 10;
    localparam int TW = 16;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          op_start_i = 1'b0;
    logic [1:0]    op_type_i = 2'd0;
    logic [AW-1:0] op_addr_i = '0;
    logic [CW-1:0] op_num_pages_i = '0;
    logic [TW-1:0] op_timeout_i = '0;
    logic          busy_o;
    logic          op_done_o;
    logic          op_err_o;
    logic [2:0]    op_err_code_o;
    logic          flash_req_o;
    logic          flash_op_o;
    logic [AW-1:0] flash_addr_o;
    logic          flash_done_i = 1'b0;
    logic          flash_error_i = 1'b0;

    always #5 clk_i = ~clk_i;

    flash_erase_seq dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .op_start_i     (op_start_i),
        .op_type_i      (op_type_i),
        .op_addr_i      (op_addr_i),
        .op_num_pages_i (op_num_pages_i),
        .op_timeout_i   (op_timeout_i),
        .busy_o         (busy_o),
        .op_done_o      (op_done_o),
        .op_err_o       (op_err_o),
        .op_err_code_o  (op_err_code_o),
        .flash_req_o    (flash_req_o),
        .flash_op_o     (flash_op_o),
        .flash_addr_o   (flash_addr_o),
        .flash_done_i   (flash_done_i),
        .flash_error_i  (flash_error_i)
    );

    typedef struct packed {
        logic [AW-1:0] addr;
        logic          op;
    } req_t;

    int         checks = 0;
    int         failures = 0;
    int         req_rises = 0;
    int         req_high = 0;
    req_t       exp_req_q[$];
    logic [2:0] exp_done_q[$];
    req_t       mon_req;
    logic [2:0] mon_code;
    logic       prev_req = 1'b0;
    logic [AW-1:0] prev_addr = '0;
    int         lat;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [AW-1:0] page_of(input logic [AW-1:0] a);
        return a & ~AW'(17'h000FF);
    endfunction

    function automatic logic [AW-1:0] bank_of(input logic [AW-1:0] a);
        return a & ~AW'(17'h0FFFF);
    endfunction

    task automatic push_range(input logic [AW-1:0] a, input int n);
        for (int i = 0; i < n; i++) begin
            exp_req_q.push_back('{addr: page_of(a) + AW'(i * 256), op: 1'b0});
        end
    endtask

    always @(negedge clk_i) begin
        if (rst_ni) begin
            if (flash_req_o) begin
                req_high++;
                if (!prev_req) begin
                    req_rises++;
                    check("req_expected", 32'(exp_req_q.size() != 0), 32'd1);
                    if (exp_req_q.size() != 0) begin
                        mon_req = exp_req_q.pop_front();
                        check("req_addr", 32'(flash_addr_o), 32'(mon_req.addr));
                        check("req_op", 32'(flash_op_o), 32'(mon_req.op));
                    end
                end else begin
                    check("req_addr_stable", 32'(flash_addr_o), 32'(prev_addr));
                end
            end else begin
                check("idle_op_addr_zero", 32'({flash_op_o, flash_addr_o}), 32'd0);
            end
            if (op_done_o) begin
                check("done_expected", 32'(exp_done_q.size() != 0), 32'd1);
                if (exp_done_q.size() != 0) begin
                    mon_code = exp_done_q.pop_front();
                    check("err_code", 32'(op_err_code_o), 32'(mon_code));
                    check("err_flag", 32'(op_err_o), 32'(mon_code != 3'b000));
                end
            end
            prev_req  = flash_req_o;
            prev_addr = flash_addr_o;
        end else begin
            prev_req = 1'b0;
        end
    end

    task automatic run_op(input logic [1:0] typ, input logic [AW-1:0] addr,
                          input logic [CW-1:0] cnt, input logic [TW-1:0] tmo,
                          input int delay, input int err_idx, input bit silent,
                          output int latency);
        int   wait_cnt = 0;
        int   req_idx = 0;
        bit   seen = 1'b0;
        logic prev = 1'b0;
        latency = -1;
        req_rises = 0;
        req_high = 0;
        @(negedge clk_i);
        op_start_i     = 1'b1;
        op_type_i      = typ;
        op_addr_i      = addr;
        op_num_pages_i = cnt;
        op_timeout_i   = tmo;
        @(negedge clk_i);
        op_start_i = 1'b0;
        check("busy_after_accept", 32'(busy_o), 32'd1);
        for (int n = 0; n < 400 && !seen; n++) begin
            if (n > 0) @(negedge clk_i);
            flash_done_i  = 1'b0;
            flash_error_i = 1'b0;
            if (op_done_o) begin
                seen    = 1'b1;
                latency = n;
            end else if (flash_req_o) begin
                if (!prev) begin
                    req_idx++;
                    wait_cnt = 0;
                end
                wait_cnt++;
                if (!silent && wait_cnt == delay + 1) begin
                    flash_done_i  = 1'b1;
                    flash_error_i = (req_idx == err_idx);
                end
            end
            prev = flash_req_o;
        end
        flash_done_i  = 1'b0;
        flash_error_i = 1'b0;
        check("op_done_seen", 32'(seen), 32'd1);
        @(negedge clk_i);
        check("done_single_cycle", 32'(op_done_o), 32'd0);
        check("busy_clear_after_done", 32'(busy_o), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk_i);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_done", 32'(op_done_o), 32'd0);
        check("rst_err", 32'(op_err_o), 32'd0);
        check("rst_code", 32'(op_err_code_o), 32'd0);
        check("rst_req", 32'(flash_req_o), 32'd0);
        check("rst_op", 32'(flash_op_o), 32'd0);
        check("rst_addr", 32'(flash_addr_o), 32'd0);
        rst_ni = 1'b1;
        @(negedge clk_i);

        // single page erase, phy answers after a few wait cycles
        exp_req_q.push_back('{addr: page_of(17'h01234), op: 1'b0});
        exp_done_q.push_back(3'b000);
        run_op(2'd0, 17'h01234, 10'd0, 16'd100, 5, 0, 1'b0, lat);
        check("page_req_pulses", 32'(req_rises), 32'd1);

        // bank erase
        exp_req_q.push_back('{addr: bank_of(17'h12345), op: 1'b1});
        exp_done_q.push_back(3'b000);
        run_op(2'd1, 17'h12345, 10'd7, 16'd0, 3, 0, 1'b0, lat);
        check("bank_req_pulses", 32'(req_rises), 32'd1);

        // three-page range with immediate phy completion
        push_range(17'h00100, 3);
        exp_done_q.push_back(3'b000);
        run_op(2'd2, 17'h00100, 10'd3, 16'd0, 0, 0, 1'b0, lat);
        check("range3_req_pulses", 32'(req_rises), 32'd3);

        // range ending exactly at the last page is legal
        push_range(17'h1FE00, 2);
        exp_done_q.push_back(3'b000);
        run_op(2'd2, 17'h1FE00, 10'd2, 16'd0, 1, 0, 1'b0, lat);
        check("range_edge_req_pulses", 32'(req_rises), 32'd2);

        // range one page past the end is rejected without touching the phy
        exp_done_q.push_back(3'b100);
        run_op(2'd2, 17'h1FE00, 10'd3, 16'd0, 0, 0, 1'b0, lat);
        check("range_over_latency", 32'(lat), 32'd0);
        check("range_over_no_req", 32'(req_rises), 32'd0);

        exp_done_q.push_back(3'b100);
        run_op(2'd3, 17'h00400, 10'd1, 16'd0, 0, 0, 1'b0, lat);
        check("illegal_latency", 32'(lat), 32'd0);
        check("illegal_no_req", 32'(req_rises), 32'd0);

        exp_done_q.push_back(3'b100);
        run_op(2'd2, 17'h00400, 10'd0, 16'd0, 0, 0, 1'b0, lat);
        check("range_zero_no_req", 32'(req_rises), 32'd0);

        // silent phy: request held for exactly the timeout, then timeout error
        exp_req_q.push_back('{addr: page_of(17'h00300), op: 1'b0});
        exp_done_q.push_back(3'b010);
        run_op(2'd0, 17'h00300, 10'd0, 16'd8, 0, 0, 1'b1, lat);
        check("timeout_req_cycles", 32'(req_high), 32'd8);
        check("timeout_req_pulses", 32'(req_rises), 32'd1);

        // error coincident with done on page 2 abandons pages 3 and 4
        push_range(17'h00000, 2);
        exp_done_q.push_back(3'b001);
        run_op(2'd2, 17'h00000, 10'd4, 16'd0, 0, 2, 1'b0, lat);
        check("err_range_req_pulses", 32'(req_rises), 32'd2);

        // phy strobes outside Wait are ignored
        @(negedge clk_i);
        flash_done_i  = 1'b1;
        flash_error_i = 1'b1;
        @(negedge clk_i);
        flash_done_i  = 1'b0;
        flash_error_i = 1'b0;
        @(negedge clk_i);
        check("stray_strobe_outputs", 32'({busy_o, op_done_o, op_err_o, flash_req_o}), 32'd0);

        // reset during Wait drops everything at once and never completes the op
        exp_req_q.push_back('{addr: page_of(17'h00540), op: 1'b0});
        op_start_i     = 1'b1;
        op_type_i      = 2'd0;
        op_addr_i      = 17'h00540;
        op_timeout_i   = 16'd0;
        @(negedge clk_i);
        op_start_i = 1'b0;
        repeat (4) @(negedge clk_i);
        check("pre_reset_req", 32'(flash_req_o), 32'd1);
        rst_ni = 1'b0;
        #1;
        check("async_reset_outputs",
              32'({busy_o, op_done_o, op_err_o, op_err_code_o, flash_req_o, flash_op_o, flash_addr_o}),
              32'd0);
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        check("post_reset_no_done", 32'({busy_o, op_done_o}), 32'd0);

        exp_req_q.push_back('{addr: page_of(17'h00777), op: 1'b0});
        exp_done_q.push_back(3'b000);
        run_op(2'd0, 17'h00777, 10'd0, 16'd0, 2, 0, 1'b0, lat);
        check("post_reset_req_pulses", 32'(req_rises), 32'd1);

        repeat (2) @(negedge clk_i);
        check("req_queue_drained", 32'(exp_req_q.size()), 32'd0);
        check("done_queue_drained", 32'(exp_done_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
